// File: rtl/counter_period_averager_if.sv
// Control/status bundle between the period averager and its host and trigger.
interface counter_period_averager_if #(
    parameter int COUNTER_WIDTH = 32,
    parameter int LOG2_DEPTH    = 3
);
    logic                     enable;
    logic [COUNTER_WIDTH-1:0] last_counter;
    logic                     trigger_armed;
    logic [LOG2_DEPTH:0]      avg_shift;
    logic [COUNTER_WIDTH-1:0] min_period;
    logic [COUNTER_WIDTH-1:0] reference_counter;
    logic                     reference_valid;
    logic [15:0]              period_count;
    logic [15:0]              reject_count;

    modport master (
        output enable, last_counter, trigger_armed, avg_shift, min_period,
        input  reference_counter, reference_valid, period_count, reject_count
    );
    modport slave (
        input  enable, last_counter, trigger_armed, avg_shift, min_period,
        output reference_counter, reference_valid, period_count, reject_count
    );
endinterface

// File: rtl/counter_period_averager.sv
// Moving average of the trigger's last full period over 2^min(avg_shift,LOG2_DEPTH) samples.
// Define COUNTER_PERIOD_AVERAGER_MIN_PERIOD_EN to reject periods shorter than min_period.
module counter_period_averager #(
    parameter int COUNTER_WIDTH = 32,
    parameter int LOG2_DEPTH    = 3
) (
    input logic clk,
    input logic reset,
    counter_period_averager_if.slave bus
);
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SUM_W = COUNTER_WIDTH + LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] MAX_SHIFT = (LOG2_DEPTH+1)'(LOG2_DEPTH);

    logic [LOG2_DEPTH:0]      s_eff, s_eff_q, n_win, fill;
    logic [LOG2_DEPTH-1:0]    wp, wp_ahead, old_idx;
    logic [COUNTER_WIDTH-1:0] ring [DEPTH];
    logic [COUNTER_WIDTH-1:0] prev, s1_x, s1_old, old_val, ref_q;
    logic [SUM_W-1:0]         sum;
    logic                     flush, cand, too_short, s1_acc, s1_rej, valid_q;
    logic [15:0]              period_q, reject_q;

    assign s_eff = (bus.avg_shift > MAX_SHIFT) ? MAX_SHIFT : bus.avg_shift;
    assign n_win = (LOG2_DEPTH+1)'(1) << s_eff;
    assign flush = !bus.enable || (s_eff != s_eff_q);
    assign cand  = bus.enable && !bus.trigger_armed && (bus.last_counter != prev);

`ifdef COUNTER_PERIOD_AVERAGER_MIN_PERIOD_EN
    assign too_short = bus.last_counter < bus.min_period;
`else
    logic unused_min_period;
    assign unused_min_period = ^bus.min_period;
    assign too_short = 1'b0;
`endif

    // Oldest entry is found relative to where wp will be once the stage-1 sample lands;
    // if that slot is the one being written this edge, take the in-flight value.
    assign wp_ahead = wp + LOG2_DEPTH'(s1_acc);
    assign old_idx  = wp_ahead - n_win[LOG2_DEPTH-1:0];
    assign old_val  = (s1_acc && old_idx == wp) ? s1_x : ring[old_idx];

    always_ff @(posedge clk) begin
        if (s1_acc) ring[wp] <= s1_x;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev     <= '0;
            s_eff_q  <= '0;
            s1_acc   <= 1'b0;
            s1_rej   <= 1'b0;
            s1_x     <= '0;
            s1_old   <= '0;
            sum      <= '0;
            fill     <= '0;
            wp       <= '0;
            period_q <= '0;
            reject_q <= '0;
            ref_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            prev    <= bus.last_counter;
            s_eff_q <= s_eff;
            if (flush) begin
                s1_acc   <= 1'b0;
                s1_rej   <= 1'b0;
                sum      <= '0;
                fill     <= '0;
                wp       <= '0;
                period_q <= '0;
                reject_q <= '0;
                ref_q    <= '0;
                valid_q  <= 1'b0;
            end else begin
                s1_acc <= cand && !too_short;
                s1_rej <= cand && too_short;
                s1_x   <= bus.last_counter;
                s1_old <= old_val;
                if (s1_acc) begin
                    if (fill == n_win) begin
                        sum <= sum + SUM_W'(s1_x) - SUM_W'(s1_old);
                    end else begin
                        sum  <= sum + SUM_W'(s1_x);
                        fill <= fill + (LOG2_DEPTH+1)'(1);
                    end
                    wp <= wp + LOG2_DEPTH'(1);
                    if (period_q != 16'hFFFF) period_q <= period_q + 16'd1;
                end
                if (s1_rej && reject_q != 16'hFFFF) reject_q <= reject_q + 16'd1;
                ref_q   <= COUNTER_WIDTH'(sum >> s_eff);
                valid_q <= (fill == n_win);
            end
        end
    end

    assign bus.reference_counter = ref_q;
    assign bus.reference_valid   = valid_q;
    assign bus.period_count      = period_q;
    assign bus.reject_count      = reject_q;
endmodule
